// File: rtl/vote_pkg.sv
// Purpose: shared types and constants for the vote collector (FSM states, verdict codes).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vote_pkg;

    localparam int NUM_VOTERS = 4;
    localparam int ID_W       = $clog2(NUM_VOTERS);

    // One-hot verdict codes, bit positions match O[3:1].
    localparam logic [3:1] VERDICT_YES = 3'b100;
    localparam logic [3:1] VERDICT_TIE = 3'b010;
    localparam logic [3:1] VERDICT_NO  = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    // Number of yes votes in a ballot.
    function automatic logic [2:0] popcount(input logic [NUM_VOTERS-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/vote_collector_if.sv
// Purpose: vote channel (valid/ready) between a vote source and the collector.
// Latency: n/a (wires only).
// Backpressure: vote_ready low means the collector is not taking votes; the source holds.
// Ports: vote_valid/vote_id/vote_val from master, vote_ready from slave.
interface vote_collector_if;
    import vote_pkg::*;

    logic            vote_valid;
    logic [ID_W-1:0] vote_id;
    logic            vote_val;
    logic            vote_ready;

    modport master (output vote_valid, output vote_id, output vote_val, input vote_ready);
    modport slave  (input vote_valid, input vote_id, input vote_val, output vote_ready);

endinterface

// File: rtl/vote_tally.sv
// Purpose: maps a ballot to a one-hot verdict by counting yes votes.
// Latency: combinational.
// Backpressure: none.
// Ports: ballot (one bit per voter) in, O[3:1] verdict out.
module vote_tally
    import vote_pkg::*;
(
    input  logic [NUM_VOTERS-1:0] ballot,
    output logic [3:1]            O
);

    logic [2:0] yes_cnt;

    always_comb begin
        yes_cnt = popcount(ballot);
        if (yes_cnt >= 3'd3) begin
            O = VERDICT_YES;
        end else if (yes_cnt == 3'd2) begin
            O = VERDICT_TIE;
        end else begin
            O = VERDICT_NO;
        end
    end

endmodule

// File: rtl/vote_collector.sv
// Purpose: collects one vote per voter per round and issues a registered majority verdict.
// Latency: verdict (done/O) one cycle after the closing vote, or TIMEOUT_CYCLES after round start.
// Backpressure: vote_ready high only while collecting; duplicates are dropped and flagged.
// Ports: clk, rst (sync, active-high), start, vote (slave modport), ballot, O[3:1], done,
//        timeout, dup_err.
module vote_collector
    import vote_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    vote_collector_if.slave       vote,
    output logic [NUM_VOTERS-1:0] ballot,
    output logic [3:1]            O,
    output logic                  done,
    output logic                  timeout,
    output logic                  dup_err
);

    localparam int         TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
    logic [NUM_VOTERS-1:0] mask_q, mask_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  timeout_q, timeout_d;
    logic [3:1]            o_q, o_d;
    logic                  dup_err_q, dup_err_d;
    logic [3:1]            verdict;

    // Ballot / mask / duplicate detection. Kept apart from the FSM logic so the
    // tally can look at the post-vote ballot without a combinational loop.
    always_comb begin
        ballot_d  = ballot_q;
        mask_d    = mask_q;
        dup_err_d = 1'b0;
        if (state_q == IDLE && start) begin
            ballot_d = '0;
            mask_d   = '0;
        end else if (state_q == COLLECT && vote.vote_valid) begin
            if (mask_q[vote.vote_id]) begin
                dup_err_d = 1'b1;
            end else begin
                ballot_d[vote.vote_id] = vote.vote_val;
                mask_d[vote.vote_id]   = 1'b1;
            end
        end
    end

    // Tally the ballot as it will be after this edge, so the closing vote counts.
    vote_tally u_tally (
        .ballot (ballot_d),
        .O      (verdict)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        o_d       = 3'b000;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = COLLECT;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            COLLECT: begin
                // A complete mask wins over an expiring timer on the same edge.
                if (&mask_d) begin
                    state_d   = RESULT;
                    timeout_d = 1'b0;
                    o_d       = verdict;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = RESULT;
                    timeout_d = 1'b1;
                    o_d       = verdict;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESULT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            o_q       <= 3'b000;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            o_q       <= o_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ballot_q  <= '0;
            mask_q    <= '0;
            dup_err_q <= 1'b0;
        end else begin
            ballot_q  <= ballot_d;
            mask_q    <= mask_d;
            dup_err_q <= dup_err_d;
        end
    end

    assign vote.vote_ready = (state_q == COLLECT);
    assign done            = (state_q == RESULT);
    assign ballot          = ballot_q;
    assign O               = o_q;
    assign timeout         = timeout_q;
    assign dup_err         = dup_err_q;

endmodule

// File: tb/tb_vote_collector.sv
// Purpose: randomized and directed rounds against a round-level reference model with a scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_vote_collector;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ballot;
    logic [3:1] O;
    logic       done;
    logic       timeout;
    logic       dup_err;

    vote_collector_if vif ();

    vote_collector #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .vote    (vif),
        .ballot  (ballot),
        .O       (O),
        .done    (done),
        .timeout (timeout),
        .dup_err (dup_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] ballot;
        logic [3:1] o;
        logic       to;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   dup_q[$];
    exp_t mx;
    int   md;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Per-cycle stimulus for the COLLECT phase of one round (index = cycles since entry).
    logic       s_vld[32];
    logic [1:0] s_id[32];
    logic       s_val[32];
    int         s_n;

    task automatic clear_stim();
        s_n = 0;
    endtask

    task automatic add(input logic vld, input logic [1:0] id, input logic val);
        s_vld[s_n] = vld;
        s_id[s_n]  = id;
        s_val[s_n] = val;
        s_n++;
    endtask

    task automatic run_round();
        int         e;
        int         kc;
        int         cnt;
        logic [3:0] m;
        logic [3:0] b;
        logic       to;
        exp_t       x;
        start          = 1'b1;
        vif.vote_valid = 1'($urandom_range(0, 1));
        vif.vote_id    = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
        e = cyc;
        // Reference model: first vote per voter counts, round ends when all four are in
        // or after T cycles of collecting, whichever comes first (full ballot wins a tie).
        m  = 4'h0;
        b  = 4'h0;
        kc = T - 1;
        to = 1'b1;
        for (int k = 0; k < T; k++) begin
            if (k < s_n && s_vld[k]) begin
                if (m[s_id[k]]) dup_q.push_back(e + k + 1);
                else begin
                    m[s_id[k]] = 1'b1;
                    b[s_id[k]] = s_val[k];
                end
            end
            if (m == 4'hf) begin
                kc = k;
                to = 1'b0;
                break;
            end
        end
        cnt      = $countones(b);
        x.ballot = b;
        x.o      = (cnt >= 3) ? 3'b100 : (cnt == 2) ? 3'b010 : 3'b001;
        x.to     = to;
        x.cyc    = e + kc + 1;
        exp_q.push_back(x);
        for (int k = 0; k <= kc; k++) begin
            vif.vote_valid = (k < s_n) ? s_vld[k] : 1'b0;
            vif.vote_id    = (k < s_n) ? s_id[k] : 2'($urandom_range(0, 3));
            vif.vote_val   = (k < s_n) ? s_val[k] : 1'($urandom_range(0, 1));
            start          = 1'($urandom_range(0, 1));
            chk("vote_ready_collect", 32'(vif.vote_ready), 32'd1);
            @(posedge clk); #1;
        end
        // RESULT cycle: start and votes must be ignored.
        start          = 1'($urandom_range(0, 1));
        vif.vote_valid = 1'($urandom_range(0, 1));
        vif.vote_id    = 2'($urandom_range(0, 3));
        chk("vote_ready_result", 32'(vif.vote_ready), 32'd0);
        @(posedge clk); #1;
        // Back in IDLE: verdict gone, ballot held.
        start          = 1'b0;
        vif.vote_valid = 1'($urandom_range(0, 1));
        chk("vote_ready_idle", 32'(vif.vote_ready), 32'd0);
        chk("done_after_result", 32'(done), 32'd0);
        chk("o_after_result", 32'(O), 32'd0);
        chk("ballot_hold", 32'(ballot), 32'(b));
        @(posedge clk); #1;
        vif.vote_valid = 1'b0;
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mx = exp_q.pop_front();
                    chk("verdict_cycle", 32'(cyc), 32'(mx.cyc));
                    chk("verdict_o", 32'(O), 32'(mx.o));
                    chk("verdict_ballot", 32'(ballot), 32'(mx.ballot));
                    chk("verdict_timeout", 32'(timeout), 32'(mx.to));
                end
            end else begin
                chk("o_zero_when_not_done", 32'(O), 32'd0);
            end
            if (dup_err !== 1'b0) begin
                if (dup_q.size() == 0) begin
                    chk("unexpected_dup_err", 32'(dup_err), 32'd0);
                end else begin
                    md = dup_q.pop_front();
                    chk("dup_err_cycle", 32'(cyc), 32'(md));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p[4];
        int j;
        int t;
        rst            = 1'b1;
        start          = 1'b0;
        vif.vote_valid = 1'b0;
        vif.vote_id    = 2'd0;
        vif.vote_val   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ballot", 32'(ballot), 32'd0);
        chk("rst_o", 32'(O), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_dup_err", 32'(dup_err), 32'd0);
        chk("rst_vote_ready", 32'(vif.vote_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Yes-majority with consecutive votes.
        clear_stim(); add(1, 0, 1); add(1, 1, 1); add(1, 2, 1); add(1, 3, 0);
        run_round();
        // Tie.
        clear_stim(); add(1, 0, 1); add(1, 1, 0); add(1, 2, 1); add(1, 3, 0);
        run_round();
        // Timeout with a single yes vote.
        clear_stim(); add(0, 0, 0); add(1, 2, 1);
        run_round();
        // Duplicate id1, then complete.
        clear_stim(); add(1, 1, 1); add(1, 1, 0); add(1, 0, 1); add(1, 2, 1); add(1, 3, 0);
        run_round();
        // Fourth vote lands on the last timer cycle: normal completion.
        clear_stim(); add(1, 0, 0); add(1, 1, 1); add(1, 2, 0);
        for (int k = 3; k < T - 1; k++) add(0, 0, 0);
        add(1, 3, 1);
        run_round();

        // Reset in the middle of a round: no verdict, all outputs cleared.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vif.vote_valid = 1'b1; vif.vote_id = 2'd0; vif.vote_val = 1'b1;
        @(posedge clk); #1;
        vif.vote_id = 2'd1;
        @(posedge clk); #1;
        rst = 1'b1; vif.vote_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ballot", 32'(ballot), 32'd0);
        chk("midrst_o", 32'(O), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        chk("midrst_dup_err", 32'(dup_err), 32'd0);
        chk("midrst_vote_ready", 32'(vif.vote_ready), 32'd0);
        @(posedge clk); #1;
        clear_stim(); add(1, 0, 1); add(1, 1, 1); add(1, 2, 1); add(1, 3, 1);
        run_round();

        // Every ballot value, random voter order and random gaps.
        for (int bv = 0; bv < 16; bv++) begin
            for (int i = 0; i < 4; i++) p[i] = i;
            for (int i = 3; i > 0; i--) begin
                j    = $urandom_range(0, i);
                t    = p[i];
                p[i] = p[j];
                p[j] = t;
            end
            clear_stim();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) add(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                add(1, 2'(p[i]), 1'((bv >> p[i]) & 1));
            end
            run_round();
        end

        // Random rounds: duplicates, gaps, timeouts.
        for (int r = 0; r < 30; r++) begin
            clear_stim();
            t = $urandom_range(1, 20);
            for (int k = 0; k < t; k++) begin
                add(1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            run_round();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("verdicts_outstanding", 32'(exp_q.size()), 32'd0);
        chk("dup_pulses_outstanding", 32'(dup_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vote_collector.md
VOTE_COLLECTOR -- requirements
Module: vote_collector

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in COLLECT before the round closes with missing votes counted as 0.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  opens a new voting round; sampled only in IDLE.
REQ-005 vote_valid  input  1  vote present on vote_id/vote_val this cycle.
REQ-006 vote_id  input  2  voter index 0..3.
REQ-007 vote_val  input  1  1 = yes, 0 = no.
REQ-008 vote_ready  output  1  high only in COLLECT; a vote transfers when vote_valid && vote_ready.
REQ-009 ballot  output  4  registered vote vector, bit n = voter n, unreceived voters read 0.
REQ-010 O  output  3 (bits 3:1)  verdict, one-hot when done=1: O[3] yes-majority, O[2] tie, O[1] no-majority.
REQ-011 done  output  1  verdict valid; high for the whole RESULT state.
REQ-012 timeout  output  1  round closed by timer rather than by 4 votes; valid with done.
REQ-013 dup_err  output  1  one-cycle pulse when an already-received vote_id is offered.

Function
REQ-014 FSM states IDLE, COLLECT, RESULT; the reset state is IDLE.
REQ-015 IDLE -> COLLECT on start=1; entry clears ballot, the received mask, the timer, timeout and O.
REQ-016 In COLLECT, an accepted vote sets ballot[vote_id]=vote_val and mask[vote_id]=1 on the same edge.
REQ-017 A vote whose mask bit is already set is ignored (ballot unchanged) and raises dup_err on the next cycle.
REQ-018 COLLECT -> RESULT on the edge where the mask becomes 4'b1111, with timeout=0.
REQ-019 The timer counts cycles in COLLECT; COLLECT -> RESULT when the timer reaches TIMEOUT_CYCLES-1 with the mask incomplete, with timeout=1.
REQ-020 If the 4th vote and timer expiry coincide, the round completes normally with timeout=0.
REQ-021 Verdict = popcount(ballot): 3 or 4 -> O=3'b100; 2 -> O=3'b010; 0 or 1 -> O=3'b001.
REQ-022 The verdict is registered on the COLLECT->RESULT edge: done and O are valid on the first RESULT cycle, one cycle after the closing vote.
REQ-023 O=3'b000 whenever done=0.
REQ-024 RESULT lasts exactly one cycle then returns to IDLE; ballot holds its value until the next start.
REQ-025 start is ignored outside IDLE; vote_valid is ignored outside COLLECT (no dup_err, no state change).

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, ballot=0, mask=0, timer=0, O=0, done=0, timeout=0, dup_err=0, vote_ready=0.
REQ-027 rst overrides all other inputs, including mid-round; a round interrupted by reset produces no verdict.

Structure
REQ-028 A shared package vote_pkg holds the state enum, the verdict encodings (VERDICT_YES=3'b100, VERDICT_TIE=3'b010, VERDICT_NO=3'b001) and NUM_VOTERS=4.
REQ-029 The popcount-to-verdict mapping is a combinational sub-module vote_tally (ballot[3:0] in, O[3:1] out), instantiated once.
REQ-030 The timer width is $clog2(TIMEOUT_CYCLES)+1 bits, and every register sits in a single synchronous always block per register group.

Verification
REQ-031 start; votes id0..3 = 1,1,1,0 on consecutive cycles -> one cycle after the id3 vote: done=1, O=3'b100, ballot=4'b0111, timeout=0.
REQ-032 start; votes 1,0,1,0 (ids 0..3) -> O=3'b010, ballot=4'b0101; then the next cycle: done=0, O=3'b000, state IDLE.
REQ-033 start; only id2=1 is sent, then idle -> done rises TIMEOUT_CYCLES cycles after the COLLECT entry, with timeout=1, O=3'b001, ballot=4'b0100.
REQ-034 start; id1=1, then id1=0 again -> dup_err pulses one cycle, ballot[1] stays 1; completing ids 0,2,3 = 1,1,0 gives O=3'b100.
REQ-035 rst asserted after 2 votes -> next cycle all outputs 0 and vote_ready=0; a following round with 4 yes votes gives O=3'b100, timeout=0.
REQ-036 Exhaustive sweep of all 16 ballots in complete rounds -> O matches the popcount rule for each value.
